sdram_arbiter_rr: RTL and testbench

- N-client SDRAM access arbiter for the single SDRAM controller port (ar_*).
- Sits between the SD-card init loader, the PCM/I2S fetcher, the frame/line-buffer readers and the controller.
- Exclusive init phase first: the loader owns the port until init_done.
- Then fair round-robin arbitration over NUM_CLIENTS request/ack clients, with bounded burst ownership.
- Replaces the fixed frame-slot state machine with a parametrised arbiter.

---
 rtl/sdram_arbiter_rr.sv | 236 +++++++++++++++++++++++
 tb/tb_sdram_arbiter_rr.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter_rr.sv
// Round-robin SDRAM port arbiter: exclusive loader phase, then fair bounded-burst sharing of ar_* between clients.
// Grant latency: 1 cycle (ARB -> ACCESS), one ARB bubble between accesses. Optional macro: ARB_PCM_PRIORITY_EN (client 0 wins every ARB).
module sdram_arbiter_rr #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 16,
    parameter int BE_W        = 2,
    parameter int MAX_BURST   = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [ADDR_W-1:0]             init_addr,
    input  logic                          init_we,
    input  logic [DATA_W-1:0]             init_wrdata,
    input  logic                          init_done,
    output logic                          init_ac,
    input  logic [NUM_CLIENTS-1:0]        cli_req,
    input  logic [NUM_CLIENTS-1:0]        cli_we,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr,
    input  logic [NUM_CLIENTS*BE_W-1:0]   cli_be,
    input  logic [NUM_CLIENTS*DATA_W-1:0] cli_wrdata,
    output logic [NUM_CLIENTS-1:0]        cli_ac,
    output logic [NUM_CLIENTS-1:0]        cli_wait,
    output logic [DATA_W-1:0]             cli_rddata,
    output logic                          grant_valid,
    output logic [2:0]                    grant_id,
    output logic [ADDR_W-1:0]             ar_addr,
    output logic [BE_W-1:0]               ar_be,
    output logic                          ar_read,
    output logic                          ar_write,
    output logic [DATA_W-1:0]             ar_wrdata,
    input  logic                          ar_ac,
    input  logic [DATA_W-1:0]             ar_rddata
);

    localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_ARB    = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_grant_id;
    logic               r_grant_valid;
    logic [CNT_W-1:0]   r_burst_cnt;
    logic [IDX_W-1:0]   r_last_id;

    state_t             w_state_nxt;
    logic [IDX_W-1:0]   w_grant_id_nxt;
    logic               w_grant_valid_nxt;
    logic [CNT_W-1:0]   w_burst_cnt_nxt;
    logic [IDX_W-1:0]   w_last_id_nxt;

    logic               w_rr_found;
    logic [IDX_W-1:0]   w_rr_id;
    logic [IDX_W-1:0]   w_win_id;
    logic [CNT_W-1:0]   w_win_cnt;
    logic [IDX_W-1:0]   w_win_last;
    logic               w_keep;

    logic               w_sel_req;
    logic               w_sel_we;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [BE_W-1:0]    w_sel_be;
    logic [DATA_W-1:0]  w_sel_wrdata;

    // Mux the granted client's request fields.
    always_comb begin
        w_sel_req    = 1'b0;
        w_sel_we     = 1'b0;
        w_sel_addr   = '0;
        w_sel_be     = '0;
        w_sel_wrdata = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (r_grant_id == IDX_W'(i)) begin
                w_sel_req    = cli_req[i];
                w_sel_we     = cli_we[i];
                w_sel_addr   = cli_addr[i*ADDR_W +: ADDR_W];
                w_sel_be     = cli_be[i*BE_W +: BE_W];
                w_sel_wrdata = cli_wrdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Round-robin scan starting just after the last rotating winner.
    always_comb begin
        int v_target;
        v_target   = 0;
        w_rr_found = 1'b0;
        w_rr_id    = '0;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            v_target = int'(r_last_id) + k;
            if (v_target >= NUM_CLIENTS) begin
                v_target = v_target - NUM_CLIENTS;
            end
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (!w_rr_found && (i == v_target) && cli_req[i]) begin
                    w_rr_found = 1'b1;
                    w_rr_id    = IDX_W'(i);
                end
            end
        end
    end

    assign w_keep = r_grant_valid && w_sel_req && (r_burst_cnt < BURST_MAX);

    always_comb begin
        w_win_id   = w_rr_id;
        w_win_cnt  = '0;
        w_win_last = w_rr_id;
`ifdef ARB_PCM_PRIORITY_EN
        if (cli_req[0]) begin
            w_win_id   = '0;
            w_win_last = r_last_id;
            w_win_cnt  = (r_grant_valid && (r_grant_id == '0)) ? r_burst_cnt : '0;
        end else if (w_keep) begin
            w_win_id   = r_grant_id;
            w_win_cnt  = r_burst_cnt;
            w_win_last = r_last_id;
        end
`else
        if (w_keep) begin
            w_win_id   = r_grant_id;
            w_win_cnt  = r_burst_cnt;
            w_win_last = r_last_id;
        end
`endif
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_grant_id_nxt    = r_grant_id;
        w_grant_valid_nxt = r_grant_valid;
        w_burst_cnt_nxt   = r_burst_cnt;
        w_last_id_nxt     = r_last_id;
        case (r_state)
            ST_INIT: begin
                if (init_done) begin
                    w_state_nxt = ST_ARB;
                end
            end
            ST_ARB: begin
                if (|cli_req) begin
                    w_grant_id_nxt    = w_win_id;
                    w_grant_valid_nxt = 1'b1;
                    w_burst_cnt_nxt   = w_win_cnt;
                    w_last_id_nxt     = w_win_last;
                    w_state_nxt       = ST_ACCESS;
                end else begin
                    w_grant_valid_nxt = 1'b0;
                end
            end
            ST_ACCESS: begin
                // A dropped request abandons the access without an ack.
                if (!w_sel_req) begin
                    w_state_nxt = ST_ARB;
                end else if (ar_ac) begin
                    w_state_nxt = ST_ARB;
                    if (r_burst_cnt != BURST_MAX) begin
                        w_burst_cnt_nxt = r_burst_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_INIT;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_burst_cnt   <= '0;
            r_last_id     <= IDX_W'(NUM_CLIENTS - 1);
        end else begin
            r_state       <= w_state_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_burst_cnt   <= w_burst_cnt_nxt;
            r_last_id     <= w_last_id_nxt;
        end
    end

    // Outputs are gated by reset_n so nothing leaks to the controller while held in reset.
    always_comb begin
        ar_addr   = '0;
        ar_be     = '0;
        ar_read   = 1'b0;
        ar_write  = 1'b0;
        ar_wrdata = '0;
        init_ac   = 1'b0;
        cli_ac    = '0;
        cli_wait  = '1;
        if (reset_n) begin
            case (r_state)
                ST_INIT: begin
                    ar_addr   = init_addr;
                    ar_write  = init_we;
                    ar_be     = '1;
                    ar_wrdata = init_wrdata;
                    init_ac   = ar_ac;
                end
                ST_ACCESS: begin
                    ar_addr   = w_sel_addr;
                    ar_be     = w_sel_be;
                    ar_wrdata = w_sel_wrdata;
                    ar_read   = w_sel_req & ~w_sel_we;
                    ar_write  = w_sel_req & w_sel_we;
                    for (int i = 0; i < NUM_CLIENTS; i++) begin
                        if (r_grant_id == IDX_W'(i)) begin
                            cli_ac[i]   = w_sel_req & ar_ac;
                            cli_wait[i] = ~r_grant_valid;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cli_rddata  = ar_rddata;
    assign grant_valid = r_grant_valid;

    always_comb begin
        grant_id              = '0;
        grant_id[IDX_W-1:0]   = r_grant_id;
    end

endmodule

// File: tb/tb_sdram_arbiter_rr.sv
// Directed bench for sdram_arbiter_rr (4 clients, MAX_BURST=2): init phase, read, write, reset mid-access, rotation, client-0 contention.
module tb_sdram_arbiter_rr;

    localparam int N  = 4;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int BW = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [AW-1:0]   init_addr;
    logic            init_we;
    logic [DW-1:0]   init_wrdata;
    logic            init_done;
    logic            init_ac;
    logic [N-1:0]    cli_req;
    logic [N-1:0]    cli_we;
    logic [N*AW-1:0] cli_addr;
    logic [N*BW-1:0] cli_be;
    logic [N*DW-1:0] cli_wrdata;
    logic [N-1:0]    cli_ac;
    logic [N-1:0]    cli_wait;
    logic [DW-1:0]   cli_rddata;
    logic            grant_valid;
    logic [2:0]      grant_id;
    logic [AW-1:0]   ar_addr;
    logic [BW-1:0]   ar_be;
    logic            ar_read;
    logic            ar_write;
    logic [DW-1:0]   ar_wrdata;
    logic            ar_ac;
    logic [DW-1:0]   ar_rddata;

    int n_total = 0;
    int n_bad   = 0;

    sdram_arbiter_rr #(
        .NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .MAX_BURST(2)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .init_addr(init_addr), .init_we(init_we), .init_wrdata(init_wrdata),
        .init_done(init_done), .init_ac(init_ac),
        .cli_req(cli_req), .cli_we(cli_we), .cli_addr(cli_addr), .cli_be(cli_be),
        .cli_wrdata(cli_wrdata), .cli_ac(cli_ac), .cli_wait(cli_wait), .cli_rddata(cli_rddata),
        .grant_valid(grant_valid), .grant_id(grant_id),
        .ar_addr(ar_addr), .ar_be(ar_be), .ar_read(ar_read), .ar_write(ar_write),
        .ar_wrdata(ar_wrdata), .ar_ac(ar_ac), .ar_rddata(ar_rddata)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int         exp_ord [10];
    int         exp1;
    int         exp2;
    logic [3:0] v_req;

    initial begin
        reset_n     = 1'b0;
        init_addr   = 25'h0000010;
        init_we     = 1'b1;
        init_wrdata = 16'h1111;
        init_done   = 1'b0;
        cli_req     = 4'b1111;
        cli_we      = '0;
        cli_addr    = '0;
        cli_be      = '0;
        cli_wrdata  = '0;
        ar_ac       = 1'b1;
        ar_rddata   = '0;

        // Held in reset: controller strobes quiet even with init_we/ar_ac high.
        #2;
        check_val("rst_ar_write", 32'(ar_write), 32'h0);
        check_val("rst_ar_addr", 32'(ar_addr), 32'h0);
        check_val("rst_init_ac", 32'(init_ac), 32'h0);
        check_val("rst_cli_wait", 32'(cli_wait), 32'hF);
        check_val("rst_cli_ac", 32'(cli_ac), 32'h0);
        check_val("rst_gvalid", 32'(grant_valid), 32'h0);
        check_val("rst_gid", 32'(grant_id), 32'h0);

        // Release; INIT passes loader through.
        #5 reset_n = 1'b1;
        #1;
        check_val("init_ar_write", 32'(ar_write), 32'h1);
        check_val("init_ar_addr", 32'(ar_addr), 32'h10);
        check_val("init_ar_be", 32'(ar_be), 32'h3);
        check_val("init_ar_wrdata", 32'(ar_wrdata), 32'h1111);
        check_val("init_ac", 32'(init_ac), 32'h1);
        check_val("init_ar_read", 32'(ar_read), 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_val("init_cli_ac", 32'(cli_ac), 32'h0);
            check_val("init_cli_wait", 32'(cli_wait), 32'hF);
            check_val("init_gvalid", 32'(grant_valid), 32'h0);
        end

        ar_ac     = 1'b0;
        init_we   = 1'b0;
        cli_req   = '0;
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        #1;
        check_val("arb_idle_write", 32'(ar_write), 32'h0);
        check_val("arb_idle_gvalid", 32'(grant_valid), 32'h0);

        // Client 2 read.
        cli_addr[2*AW +: AW] = 25'h0001234;
        cli_req = 4'b0100;
        #1;
        check_val("rd_arb_read", 32'(ar_read), 32'h0);
        tick();
        check_val("rd_ar_read", 32'(ar_read), 32'h1);
        check_val("rd_ar_write", 32'(ar_write), 32'h0);
        check_val("rd_ar_addr", 32'(ar_addr), 32'h1234);
        check_val("rd_gid", 32'(grant_id), 32'h2);
        check_val("rd_gvalid", 32'(grant_valid), 32'h1);
        check_val("rd_cli_wait", 32'(cli_wait), 32'hB);
        tick();
        check_val("rd_hold_read", 32'(ar_read), 32'h1);
        check_val("rd_hold_ac", 32'(cli_ac), 32'h0);
        tick();
        ar_ac     = 1'b1;
        ar_rddata = 16'hBEEF;
        #1;
        check_val("rd_cli_ac", 32'(cli_ac), 32'h4);
        check_val("rd_rddata", 32'(cli_rddata), 32'hBEEF);
        tick();
        ar_ac   = 1'b0;
        cli_req = '0;
        #1;
        check_val("rd_after_read", 32'(ar_read), 32'h0);
        check_val("rd_after_ac", 32'(cli_ac), 32'h0);
        tick();
        check_val("rd_idle_gvalid", 32'(grant_valid), 32'h0);

        // Client 1 write.
        cli_addr[1*AW +: AW]   = 25'h0000055;
        cli_be[1*BW +: BW]     = 2'b01;
        cli_wrdata[1*DW +: DW] = 16'h00A5;
        cli_we  = 4'b0010;
        cli_req = 4'b0010;
        tick();
        check_val("wr_ar_write", 32'(ar_write), 32'h1);
        check_val("wr_ar_read", 32'(ar_read), 32'h0);
        check_val("wr_ar_be", 32'(ar_be), 32'h1);
        check_val("wr_ar_wrdata", 32'(ar_wrdata), 32'h00A5);
        check_val("wr_ar_addr", 32'(ar_addr), 32'h55);
        check_val("wr_cli_wait", 32'(cli_wait), 32'hD);
        check_val("wr_gid", 32'(grant_id), 32'h1);
        ar_ac = 1'b1;
        #1;
        check_val("wr_cli_ac", 32'(cli_ac), 32'h2);
        tick();
        ar_ac   = 1'b0;
        cli_req = '0;
        cli_we  = '0;
        tick();

        // Client 3 read, interrupted by reset.
        cli_addr[3*AW +: AW] = 25'h1ABCDE;
        cli_req = 4'b1000;
        tick();
        check_val("rs_ar_read", 32'(ar_read), 32'h1);
        check_val("rs_gid", 32'(grant_id), 32'h3);
        #2 reset_n = 1'b0;
        ar_ac = 1'b1;
        #1;
        check_val("rs_read_low", 32'(ar_read), 32'h0);
        check_val("rs_write_low", 32'(ar_write), 32'h0);
        check_val("rs_no_ack", 32'(cli_ac), 32'h0);
        check_val("rs_addr0", 32'(ar_addr), 32'h0);
        check_val("rs_wait", 32'(cli_wait), 32'hF);
        #2 reset_n = 1'b1;
        ar_ac = 1'b0;
        #1;
        check_val("rs_rel_gvalid", 32'(grant_valid), 32'h0);
        check_val("rs_rel_read", 32'(ar_read), 32'h0);
        tick();
        check_val("rs_init_read", 32'(ar_read), 32'h0);
        check_val("rs_init_ac", 32'(cli_ac), 32'h0);
        check_val("rs_init_wait", 32'(cli_wait), 32'hF);
        init_we   = 1'b1;
        init_addr = 25'h0000020;
        #1;
        check_val("rs_init_write", 32'(ar_write), 32'h1);
        check_val("rs_init_addr", 32'(ar_addr), 32'h20);
        init_we   = 1'b0;
        cli_req   = '0;
        init_done = 1'b1;
        tick();
        init_done = 1'b0;

        // All clients request continuously; bursts of two, rotating.
`ifdef ARB_PCM_PRIORITY_EN
        exp_ord = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
        exp_ord = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
`endif
        for (int i = 0; i < N; i++) begin
            cli_addr[i*AW +: AW] = AW'(32'h100 + i);
        end
        cli_req = 4'b1111;
        for (int a = 0; a < 10; a++) begin
            tick();
            ar_ac = 1'b1;
            #1;
            check_val($sformatf("rr_gid_%0d", a), 32'(grant_id), 32'(exp_ord[a]));
            check_val($sformatf("rr_ack_%0d", a), 32'(cli_ac), 32'(1 << exp_ord[a]));
            check_val($sformatf("rr_addr_%0d", a), 32'(ar_addr), 32'h100 + 32'(exp_ord[a]));
            tick();
            ar_ac = 1'b0;
        end
        cli_req = '0;
        tick();

        // Client 2 mid-burst, client 0 arrives.
`ifdef ARB_PCM_PRIORITY_EN
        exp1 = 0;
        exp2 = 2;
`else
        exp1 = 2;
        exp2 = 0;
`endif
        cli_req = 4'b0100;
        tick();
        check_val("pc_first_gid", 32'(grant_id), 32'h2);
        ar_ac = 1'b1;
        #1;
        tick();
        ar_ac   = 1'b0;
        cli_req = 4'b0101;
        tick();
        check_val("pc_second_gid", 32'(grant_id), 32'(exp1));
        ar_ac = 1'b1;
        #1;
        check_val("pc_second_ack", 32'(cli_ac), 32'(1 << exp1));
        tick();
        ar_ac   = 1'b0;
        v_req   = cli_req;
        v_req[exp1] = 1'b0;
        cli_req = v_req;
        tick();
        check_val("pc_third_gid", 32'(grant_id), 32'(exp2));
        ar_ac = 1'b1;
        #1;
        check_val("pc_third_ack", 32'(cli_ac), 32'(1 << exp2));
        tick();
        ar_ac   = 1'b0;
        cli_req = '0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
